dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-requester arbiter that shares the single-ported data RAM between port A (core load/store unit) and port B (debug/DMA loader).
- The RAM registers its request, so a granted request is issued to the RAM in the same cycle.
- A read returns exactly one cycle later, flagged by mem_vld.
- The arbiter tracks which port owns each outstanding read, routes the read data back to that port, and bounds how long port B may lock the bus.

Parameters:
- ADDR_W, 14, data RAM word-address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- LOCK_MAX, 16, maximum consecutive B grants while b_lock is held (range 1..255).

Ports:
- clk  in  1  clock.
- rst_b  in  1  synchronous active-low reset.
- a_rd  in  1  port A read request.
- a_wr  in  1  port A write request.
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  DATA_W  port A write data.
- a_byte_en  in  DATA_W/8  port A byte enables.
- a_gnt  out  1  port A request accepted this cycle.
- a_rdata  out  DATA_W  port A read data.
- a_rvld  out  1  port A read data valid.
- b_rd, b_wr, b_addr, b_wdata, b_byte_en  in  same widths as port A  port B request fields.
- b_lock  in  1  port B asks to keep ownership across consecutive cycles.
- b_gnt  out  1  port B request accepted this cycle.
- b_rdata  out  DATA_W  port B read data.
- b_rvld  out  1  port B read data valid.
- core_stall  out  1  port A request present but not granted.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_byte_en  out  DATA_W/8  RAM byte enables.
- mem_rd  out  1  RAM read strobe.
- mem_wr  out  1  RAM write strobe.
- mem_rdata  in  DATA_W  RAM read data.
- mem_vld  in  1  RAM read data valid, one cycle after mem_rd.
- err  out  1  sticky protocol error flag.

Behaviour:
- Request definitions: a_req = a_rd|a_wr; b_req = b_rd|b_wr. A port asserting both rd and wr is treated as a write only; rd is ignored.
- Grant logic is combinational. At most one of a_gnt/b_gnt is high per cycle, and a grant is issued only to a requesting port.
- Mux: mem_* take the granted port's fields. With no grant: mem_rd = mem_wr = 0, mem_byte_en = 0, mem_addr/mem_wdata hold the port A fields.
- Arbitration state: last_b (1 bit, B granted last), lock_cnt (8 bits), owner (1 bit, 0 = A, 1 = B), rd_pend (1 bit).
- Round-robin: if only one port requests, it wins. If both request, the port not granted last wins.
- Lock:
  - If B was granted last cycle and b_lock = 1 and b_req = 1 and lock_cnt < LOCK_MAX, B wins even if A requests.
  - lock_cnt increments on each locked B grant.
  - When lock_cnt reaches LOCK_MAX, the next contested cycle goes to A, and lock_cnt clears.
  - lock_cnt clears whenever B is not granted or b_lock = 0.
- Read tracking: on a granted read, rd_pend <= 1 and owner <= the granted port. The next cycle, mem_vld is routed: a_rvld = mem_vld & rd_pend & ~owner; b_rvld = mem_vld & rd_pend & owner.
- A new read granted in the same cycle that mem_vld returns overwrites owner/rd_pend. Back-to-back reads therefore sustain 1 read per cycle.
- a_rdata and b_rdata both equal mem_rdata; data is valid only when the matching rvld is high.
- core_stall = a_req & ~a_gnt.
- err: set sticky when mem_vld = 1 with rd_pend = 0, or when rd_pend = 1 and mem_vld = 0. Cleared only by reset.
- Reset (rst_b = 0 at a clk edge): last_b = 0, lock_cnt = 0, owner = 0, rd_pend = 0, err = 0. During reset all grants are 0, so mem_rd/mem_wr/a_rvld/b_rvld = 0.
- A read in flight when reset asserts is dropped; mem_vld in the cycle after reset deasserts is ignored and does not set err.

Optional Feature:
- Macro: DMEM_ARB_FIXED_PRIO_EN.
- Defined: port A always wins when both ports request. b_lock and lock_cnt are ignored (lock_cnt held at 0). core_stall is never asserted due to B.
- Undefined: round-robin with bounded B lock, as described above.

Test Plan:
- A-only read of 0x010 with mem_rdata = 0xDEADBEEF: a_gnt = 1 and mem_rd = 1 in cycle 0; a_rvld = 1 with a_rdata = 0xDEADBEEF in cycle 1; b_rvld = 0; err = 0.
- A and B request writes every cycle, b_lock = 0, for 4 cycles: grants alternate A, B, A, B. core_stall = 1 in cycles 1 and 3.
- B holds b_lock = 1 with LOCK_MAX = 3 and A requests continuously: B granted 4 consecutive cycles (1 initial grant + 3 locked), then A granted in cycle 4.
- Back-to-back reads A@0x001, B@0x002, A@0x003: rvld routes A, B, A in cycles 1, 2, 3 with matching data; err stays 0.
- mem_vld pulsed with no outstanding read: a_rvld = b_rvld = 0 and err = 1 from the next cycle. Reset then clears err to 0.
- Reset asserted the cycle after a granted read: no rvld is produced. After release, A write with byte_en = 0x4 drives mem_byte_en = 0x4 and mem_wr = 1 in the same cycle.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-ported data RAM between port A (core LSU)
// and port B (debug/DMA loader). Round-robin arbitration with a bounded
// B lock, one-cycle read-return routing back to the owning port, and a
// sticky protocol error flag.
// Optional build macro DMEM_ARB_FIXED_PRIO_EN: port A always wins a contested
// cycle; b_lock is ignored and the lock counter stays at zero.
`timescale 1ns/1ps

module dmem_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic                clk_i,
    input  logic                rst_b_i,
    input  logic                a_rd_i,
    input  logic                a_wr_i,
    input  logic [ADDR_W-1:0]   a_addr_i,
    input  logic [DATA_W-1:0]   a_wdata_i,
    input  logic [DATA_W/8-1:0] a_byte_en_i,
    output logic                a_gnt_o,
    output logic [DATA_W-1:0]   a_rdata_o,
    output logic                a_rvld_o,
    input  logic                b_rd_i,
    input  logic                b_wr_i,
    input  logic [ADDR_W-1:0]   b_addr_i,
    input  logic [DATA_W-1:0]   b_wdata_i,
    input  logic [DATA_W/8-1:0] b_byte_en_i,
    input  logic                b_lock_i,
    output logic                b_gnt_o,
    output logic [DATA_W-1:0]   b_rdata_o,
    output logic                b_rvld_o,
    output logic                core_stall_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    output logic [DATA_W/8-1:0] mem_byte_en_o,
    output logic                mem_rd_o,
    output logic                mem_wr_o,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_vld_i,
    output logic                err_o
);

    logic       last_b_q,   last_b_d;
    logic [7:0] lock_cnt_q, lock_cnt_d;
    logic       owner_q,    owner_d;
    logic       rd_pend_q,  rd_pend_d;
    logic       err_q,      err_d;
    // Set by reset so a read response still in flight from before reset is dropped.
    logic       vld_ign_q,  vld_ign_d;

    logic a_req, b_req;
    logic a_is_rd, b_is_rd;
    logic lock_hit;
    logic a_gnt, b_gnt;

    // Grant decision: round-robin with a bounded B lock, no grants during reset.
    always_comb begin
        a_req   = a_rd_i | a_wr_i;
        b_req   = b_rd_i | b_wr_i;
        a_is_rd = a_rd_i & ~a_wr_i;
        b_is_rd = b_rd_i & ~b_wr_i;
`ifdef DMEM_ARB_FIXED_PRIO_EN
        lock_hit = 1'b0;
        b_gnt    = rst_b_i & b_req & ~a_req;
`else
        lock_hit = last_b_q & b_lock_i & b_req & (lock_cnt_q < 8'(LOCK_MAX));
        b_gnt    = rst_b_i & b_req & (~a_req | lock_hit | ~last_b_q);
`endif
        a_gnt    = rst_b_i & a_req & ~b_gnt;
    end

    // RAM request mux; with no grant the A fields sit on addr/wdata, strobes low.
    always_comb begin
        mem_addr_o    = a_addr_i;
        mem_wdata_o   = a_wdata_i;
        mem_byte_en_o = '0;
        mem_rd_o      = 1'b0;
        mem_wr_o      = 1'b0;
        if (a_gnt) begin
            mem_byte_en_o = a_byte_en_i;
            mem_rd_o      = a_is_rd;
            mem_wr_o      = a_wr_i;
        end else if (b_gnt) begin
            mem_addr_o    = b_addr_i;
            mem_wdata_o   = b_wdata_i;
            mem_byte_en_o = b_byte_en_i;
            mem_rd_o      = b_is_rd;
            mem_wr_o      = b_wr_i;
        end
    end

    // Port-side outputs: grants, stall and read-return routing.
    always_comb begin
        a_gnt_o      = a_gnt;
        b_gnt_o      = b_gnt;
        core_stall_o = a_req & ~a_gnt;
        a_rdata_o    = mem_rdata_i;
        b_rdata_o    = mem_rdata_i;
        a_rvld_o     = rst_b_i & mem_vld_i & rd_pend_q & ~owner_q;
        b_rvld_o     = rst_b_i & mem_vld_i & rd_pend_q &  owner_q;
        err_o        = err_q;
    end

    // Next-state for arbitration history, read ownership and error tracking.
    always_comb begin
        last_b_d = last_b_q;
        if (a_gnt | b_gnt) begin
            last_b_d = b_gnt;
        end
`ifdef DMEM_ARB_FIXED_PRIO_EN
        lock_cnt_d = '0;
`else
        lock_cnt_d = lock_cnt_q;
        if (!b_gnt || !b_lock_i) begin
            lock_cnt_d = '0;
        end else if (lock_hit) begin
            lock_cnt_d = lock_cnt_q + 8'd1;
        end
`endif
        // A new read overwrites ownership even when a response returns this cycle.
        rd_pend_d = mem_rd_o;
        owner_d   = mem_rd_o ? b_gnt : owner_q;
        err_d     = err_q
                  | (~vld_ign_q & mem_vld_i & ~rd_pend_q)
                  | (rd_pend_q & ~mem_vld_i);
        vld_ign_d = 1'b0;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_b_i) begin
            last_b_q   <= 1'b0;
            lock_cnt_q <= '0;
            owner_q    <= 1'b0;
            rd_pend_q  <= 1'b0;
            err_q      <= 1'b0;
            vld_ign_q  <= 1'b1;
        end else begin
            last_b_q   <= last_b_d;
            lock_cnt_q <= lock_cnt_d;
            owner_q    <= owner_d;
            rd_pend_q  <= rd_pend_d;
            err_q      <= err_d;
            vld_ign_q  <= vld_ign_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vector table, hand-written reset/error
// sequences, and randomized traffic checked against a behavioural model.
`timescale 1ns/1ps

module tb_dmem_arbiter;

    localparam int ADDR_W   = 14;
    localparam int DATA_W   = 32;
    localparam int BE_W     = DATA_W/8;
    localparam int LOCK_MAX = 3;

    logic              clk_i = 1'b0;
    logic              rst_b_i;
    logic              a_rd_i, a_wr_i, b_rd_i, b_wr_i, b_lock_i;
    logic [ADDR_W-1:0] a_addr_i, b_addr_i;
    logic [DATA_W-1:0] a_wdata_i, b_wdata_i;
    logic [BE_W-1:0]   a_byte_en_i, b_byte_en_i;
    logic              a_gnt_o, b_gnt_o, a_rvld_o, b_rvld_o, core_stall_o;
    logic [DATA_W-1:0] a_rdata_o, b_rdata_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic [BE_W-1:0]   mem_byte_en_o;
    logic              mem_rd_o, mem_wr_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              mem_vld_i;
    logic              err_o;

    always #5 clk_i = ~clk_i;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LOCK_MAX(LOCK_MAX)) dut (
        .clk_i(clk_i), .rst_b_i(rst_b_i),
        .a_rd_i(a_rd_i), .a_wr_i(a_wr_i), .a_addr_i(a_addr_i), .a_wdata_i(a_wdata_i),
        .a_byte_en_i(a_byte_en_i), .a_gnt_o(a_gnt_o), .a_rdata_o(a_rdata_o), .a_rvld_o(a_rvld_o),
        .b_rd_i(b_rd_i), .b_wr_i(b_wr_i), .b_addr_i(b_addr_i), .b_wdata_i(b_wdata_i),
        .b_byte_en_i(b_byte_en_i), .b_lock_i(b_lock_i), .b_gnt_o(b_gnt_o), .b_rdata_o(b_rdata_o),
        .b_rvld_o(b_rvld_o), .core_stall_o(core_stall_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_byte_en_o(mem_byte_en_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_rdata_i(mem_rdata_i),
        .mem_vld_i(mem_vld_i), .err_o(err_o)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // RAM contents as seen by the bench: 0x010 reads back 0xDEADBEEF.
    function automatic logic [DATA_W-1:0] ram_fn(input logic [ADDR_W-1:0] addr);
        return 32'hDEADBEEF ^ (32'(addr ^ 14'h010) * 32'h01010101);
    endfunction

    // Behavioural model state.
    typedef struct { bit owner_b; logic [ADDR_W-1:0] addr; } rd_t;
    rd_t pend[$];
    bit  m_last_b, m_err, m_ign;
    int  m_streak;

    // Check all outputs against the model, let the bench RAM answer, advance one cycle.
    task automatic step();
        int win;
        bit a_req, b_req, a_isrd, b_isrd, lk, e_rd, e_wr, e_ar, e_br;
        logic [ADDR_W-1:0] e_addr;
        logic [DATA_W-1:0] e_wd, nxt_data;
        logic [BE_W-1:0]   e_be;
        logic nxt_vld;
        #1;
        a_req  = a_rd_i | a_wr_i;
        b_req  = b_rd_i | b_wr_i;
        a_isrd = a_rd_i && !a_wr_i;
        b_isrd = b_rd_i && !b_wr_i;
        win = 0;
        lk  = 0;
        if (rst_b_i) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            if (a_req) win = 1; else if (b_req) win = 2;
`else
            lk = m_last_b && b_lock_i && b_req && (m_streak < LOCK_MAX);
            if (a_req && b_req) win = lk ? 2 : (m_last_b ? 1 : 2);
            else if (a_req) win = 1;
            else if (b_req) win = 2;
`endif
        end
        e_addr = a_addr_i; e_wd = a_wdata_i; e_be = '0; e_rd = 0; e_wr = 0;
        if (win == 1) begin
            e_be = a_byte_en_i; e_rd = a_isrd; e_wr = a_wr_i;
        end else if (win == 2) begin
            e_addr = b_addr_i; e_wd = b_wdata_i; e_be = b_byte_en_i; e_rd = b_isrd; e_wr = b_wr_i;
        end
        e_ar = rst_b_i && mem_vld_i && pend.size() != 0 && !pend[0].owner_b;
        e_br = rst_b_i && mem_vld_i && pend.size() != 0 &&  pend[0].owner_b;
        chk("a_gnt",   64'(a_gnt_o),       64'(win == 1));
        chk("b_gnt",   64'(b_gnt_o),       64'(win == 2));
        chk("stall",   64'(core_stall_o),  64'(a_req && win != 1));
        chk("mem_rd",  64'(mem_rd_o),      64'(e_rd));
        chk("mem_wr",  64'(mem_wr_o),      64'(e_wr));
        chk("mem_addr",64'(mem_addr_o),    64'(e_addr));
        chk("mem_wd",  64'(mem_wdata_o),   64'(e_wd));
        chk("mem_be",  64'(mem_byte_en_o), 64'(e_be));
        chk("a_rvld",  64'(a_rvld_o),      64'(e_ar));
        chk("b_rvld",  64'(b_rvld_o),      64'(e_br));
        chk("err",     64'(err_o),         64'(m_err));
        if (e_ar) chk("a_rdata", 64'(a_rdata_o), 64'(ram_fn(pend[0].addr)));
        if (e_br) chk("b_rdata", 64'(b_rdata_o), 64'(ram_fn(pend[0].addr)));
        nxt_vld  = mem_rd_o;
        nxt_data = ram_fn(mem_addr_o);
        if (!rst_b_i) begin
            m_last_b = 0; m_streak = 0; m_err = 0; m_ign = 1;
            pend.delete();
        end else begin
            if (mem_vld_i && pend.size() == 0 && !m_ign) m_err = 1;
            if (pend.size() != 0 && !mem_vld_i) m_err = 1;
            pend.delete();
            if (win == 1 && a_isrd) pend.push_back('{owner_b: 1'b0, addr: a_addr_i});
            if (win == 2 && b_isrd) pend.push_back('{owner_b: 1'b1, addr: b_addr_i});
            if (win != 0) m_last_b = (win == 2);
            if (win == 2 && b_lock_i) begin
                if (lk) m_streak++;
            end else begin
                m_streak = 0;
            end
            m_ign = 0;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        mem_vld_i   = nxt_vld;
        mem_rdata_i = nxt_data;
    endtask

    task automatic idle();
        a_rd_i = 0; a_wr_i = 0; b_rd_i = 0; b_wr_i = 0; b_lock_i = 0;
        a_addr_i = '0; b_addr_i = '0; a_wdata_i = '0; b_wdata_i = '0;
        a_byte_en_i = '0; b_byte_en_i = '0;
    endtask

    // Directed vectors; exp = {a_gnt, b_gnt, stall, mem_rd, mem_wr, a_rvld, b_rvld}.
    typedef struct {
        logic a_rd, a_wr; logic [ADDR_W-1:0] a_addr;
        logic b_rd, b_wr; logic [ADDR_W-1:0] b_addr;
        logic b_lock; logic [6:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic ard, input logic awr, input logic [ADDR_W-1:0] aad,
                                input logic brd, input logic bwr, input logic [ADDR_W-1:0] bad,
                                input logic blk, input logic [6:0] exp);
        vec_t v;
        v.a_rd = ard; v.a_wr = awr; v.a_addr = aad;
        v.b_rd = brd; v.b_wr = bwr; v.b_addr = bad;
        v.b_lock = blk; v.exp = exp;
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        tbl[0]  = mk(1,0,14'h010, 0,0,14'h000, 0, 7'b1001000); // A read 0x010
        tbl[1]  = mk(0,0,14'h000, 0,0,14'h000, 0, 7'b0000010); // data returns to A
        tbl[2]  = mk(0,0,14'h000, 0,1,14'h020, 0, 7'b0100100); // B write, B now last
        tbl[3]  = mk(0,1,14'h100, 0,1,14'h200, 0, 7'b1000100); // alternation A
        tbl[4]  = mk(0,1,14'h100, 0,1,14'h200, 0, 7'b0110100); // B
        tbl[5]  = mk(0,1,14'h100, 0,1,14'h200, 0, 7'b1000100); // A
        tbl[6]  = mk(0,1,14'h100, 0,1,14'h200, 0, 7'b0110100); // B
        tbl[7]  = mk(0,1,14'h104, 0,0,14'h000, 0, 7'b1000100); // A last
        tbl[8]  = mk(0,1,14'h108, 0,1,14'h208, 1, 7'b0110100); // B initial grant
        tbl[9]  = mk(0,1,14'h108, 0,1,14'h208, 1, 7'b0110100); // locked 1
        tbl[10] = mk(0,1,14'h108, 0,1,14'h208, 1, 7'b0110100); // locked 2
        tbl[11] = mk(0,1,14'h108, 0,1,14'h208, 1, 7'b0110100); // locked 3
        tbl[12] = mk(0,1,14'h108, 0,1,14'h208, 1, 7'b1000100); // limit hit, A
        tbl[13] = mk(0,1,14'h108, 0,1,14'h208, 1, 7'b0110100); // B again
        tbl[14] = mk(1,0,14'h001, 0,0,14'h000, 0, 7'b1001000); // A read 0x001
        tbl[15] = mk(0,0,14'h000, 1,0,14'h002, 0, 7'b0101010); // B read 0x002, A data
        tbl[16] = mk(1,0,14'h003, 0,0,14'h000, 0, 7'b1001001); // A read 0x003, B data
        tbl[17] = mk(0,0,14'h000, 0,0,14'h000, 0, 7'b0000010); // A data

        idle();
        rst_b_i = 0; mem_vld_i = 0; mem_rdata_i = '0;
        repeat (2) @(negedge clk_i);
        m_last_b = 0; m_streak = 0; m_err = 0; m_ign = 1;
        pend.delete();
        rst_b_i = 1;

        for (int i = 0; i < 18; i++) begin
            idle();
            a_rd_i = tbl[i].a_rd; a_wr_i = tbl[i].a_wr; a_addr_i = tbl[i].a_addr;
            b_rd_i = tbl[i].b_rd; b_wr_i = tbl[i].b_wr; b_addr_i = tbl[i].b_addr;
            b_lock_i = tbl[i].b_lock;
            a_wdata_i = 32'h1000_0000 | 32'(tbl[i].a_addr);
            b_wdata_i = 32'h2000_0000 | 32'(tbl[i].b_addr);
            a_byte_en_i = 4'hF; b_byte_en_i = 4'hF;
            #1;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            chk($sformatf("tbl%0d", i),
                64'({a_gnt_o, b_gnt_o, core_stall_o, mem_rd_o, mem_wr_o, a_rvld_o, b_rvld_o}),
                64'(tbl[i].exp));
`endif
            chk($sformatf("tbl%0d_err", i), 64'(err_o), 64'd0);
            if (i == 1) chk("first_rdata", 64'(a_rdata_o), 64'h0000_0000_DEAD_BEEF);
            step();
        end

        // Stray mem_vld with nothing outstanding sets the sticky error.
        idle();
        mem_vld_i = 1;
        #1;
        chk("stray_rvld", 64'({a_rvld_o, b_rvld_o}), 64'd0);
        step();
        idle();
        #1;
        chk("stray_err", 64'(err_o), 64'd1);
        step();
        rst_b_i = 0;
        step();
        rst_b_i = 1;
        #1;
        chk("err_cleared", 64'(err_o), 64'd0);
        step();

        // Reset lands while a read response is returning: it must be dropped.
        idle();
        a_rd_i = 1; a_addr_i = 14'h040;
        step();
        idle();
        rst_b_i = 0;
        #1;
        chk("rst_rvld", 64'({a_rvld_o, b_rvld_o}), 64'd0);
        step();
        rst_b_i = 1;
        idle();
        a_wr_i = 1; a_addr_i = 14'h050; a_wdata_i = 32'hCAFE_F00D; a_byte_en_i = 4'h4;
        #1;
        chk("post_rst_be", 64'(mem_byte_en_o), 64'h4);
        chk("post_rst_wr", 64'({mem_wr_o, a_gnt_o}), 64'h3);
        step();
        idle();
        #1;
        chk("post_rst_err", 64'(err_o), 64'd0);
        step();

        // Randomized traffic against the model, with occasional resets and RAM faults.
        for (int n = 0; n < 800; n++) begin
            rst_b_i     = ($urandom_range(0, 59) != 0);
            a_rd_i      = ($urandom_range(0, 9) < 4);
            a_wr_i      = ($urandom_range(0, 9) < 3);
            b_rd_i      = ($urandom_range(0, 9) < 4);
            b_wr_i      = ($urandom_range(0, 9) < 3);
            b_lock_i    = ($urandom_range(0, 3) != 0);
            a_addr_i    = ADDR_W'($urandom);
            b_addr_i    = ADDR_W'($urandom);
            a_wdata_i   = $urandom;
            b_wdata_i   = $urandom;
            a_byte_en_i = BE_W'($urandom);
            b_byte_en_i = BE_W'($urandom);
            if ($urandom_range(0, 39) == 0) mem_vld_i = ~mem_vld_i;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
